fetch_queue: RTL and testbench

Parametrised instruction-fetch front end for the pipelined RV32 core. It replaces the single-register PC/instruction buffering with three pieces:
- a credit-limited request port toward instruction memory;
- an in-order prefetch queue of {pc, instr} pairs;
- a valid/ready output to decode.
Redirects from the execute stage (taken branch, jump) flush the queue and discard in-flight stale responses. This lets memory latency and decode stalls overlap.

---
 rtl/fetch_queue_pkg.sv | 16 +
 rtl/fetch_queue_fifo.sv | 60 ++++++
 rtl/fetch_queue.sv | 108 ++++++++++
 tb/tb_fetch_queue.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the instruction-fetch front end.
package fetch_queue_pkg;

    localparam int XLEN_DEF = 32;
    localparam int INSTR_W  = 32;

    localparam logic [INSTR_W-1:0]  NOP_INSTR    = 32'h0000_0013;
    localparam logic [XLEN_DEF-1:0] RESET_PC_DEF = '0;

    // One prefetched instruction together with the address it came from.
    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [INSTR_W-1:0]  instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_fifo.sv
// In-order FIFO with a synchronous flush. A flush wins over push and pop
// in the same cycle. Reads come straight from the storage registers, so a
// pushed word is visible at the head one cycle later.
module fetch_fifo #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != CW'(DEPTH)) || w_do_pop);

    // Pointer and occupancy tracking; flush returns to the empty state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_do_push && !w_do_pop)      r_count <= r_count + CW'(1);
            else if (w_do_pop && !w_do_push) r_count <= r_count - CW'(1);
        end
    end

    // Entry storage, cleared on reset so the head reads zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_do_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: credit-limited request port, in-order
// prefetch queue of {pc, instr}, valid/ready hand-off to decode, and
// redirect handling that flushes the queue and drops stale responses.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
    input  logic               clk,
    input  logic               rst,
    output logic               o_reqValid,
    input  logic               i_reqReady,
    output logic [XLEN-1:0]    o_reqAddr,
    input  logic               i_rspValid,
    input  logic [INSTR_W-1:0] i_rspData,
    output logic               o_instrValid,
    input  logic               i_decReady,
    output logic [INSTR_W-1:0] o_instr,
    output logic [XLEN-1:0]    o_pc,
    input  logic               i_redirect,
    input  logic [XLEN-1:0]    i_redirectPc
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = XLEN + INSTR_W;

    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_rsp_pc;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_drop;

    logic [CW-1:0]   w_count;
    logic [CW:0]     w_in_flight;
    logic            w_accept;
    logic            w_push;
    logic            w_pop;
    logic [XLEN-1:0] w_redirect_pc;
    logic [EW-1:0]   w_head;
    logic            w_unused_ok;

    assign w_redirect_pc = {i_redirectPc[XLEN-1:2], 2'b00};
    assign w_unused_ok   = &{1'b0, i_redirectPc[1:0]};

    // Queued plus outstanding words may never exceed the queue size, so a
    // response always finds a free slot.
    assign w_in_flight = {1'b0, w_count} + {1'b0, r_outstanding};
    assign o_reqValid  = rst && !i_redirect && (w_in_flight < (CW+1)'(DEPTH));
    assign o_reqAddr   = r_fetch_pc;
    assign w_accept    = o_reqValid && i_reqReady;

    assign w_push = i_rspValid && !i_redirect && (r_drop == '0);
    assign w_pop  = o_instrValid && i_decReady;

    // Fetch address: redirect target, or advance by one word per accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)            r_fetch_pc <= RESET_PC;
        else if (i_redirect) r_fetch_pc <= w_redirect_pc;
        else if (w_accept)   r_fetch_pc <= r_fetch_pc + XLEN'(4);
    end

    // PC tagged onto the next kept response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)            r_rsp_pc <= RESET_PC;
        else if (i_redirect) r_rsp_pc <= w_redirect_pc;
        else if (w_push)     r_rsp_pc <= r_rsp_pc + XLEN'(4);
    end

    // Requests accepted by memory whose response has not yet arrived.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_outstanding <= '0;
        else      r_outstanding <= r_outstanding + CW'(w_accept) - CW'(i_rspValid);
    end

    // Stale responses still to discard; after a redirect this equals the
    // remaining outstanding count, so repeated redirects stay consistent.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                           r_drop <= '0;
        else if (i_redirect)                r_drop <= r_outstanding - CW'(i_rspValid);
        else if (i_rspValid && r_drop != '0) r_drop <= r_drop - CW'(1);
    end

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (i_redirect),
        .i_push  (w_push),
        .i_data  ({r_rsp_pc, i_rspData}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_count (w_count)
    );

    assign o_instrValid = (w_count != '0);
    assign o_pc         = w_head[EW-1:INSTR_W];
    assign o_instr      = w_head[INSTR_W-1:0];

`ifndef SYNTHESIS
    a_rsp_credit: assert property (@(posedge clk) disable iff (!rst)
        i_rspValid |-> (r_outstanding != '0))
        else $error("response with no fetch outstanding");
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a small in-order memory model.
module tb_fetch_queue;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            o_reqValid;
    logic            i_reqReady = 1'b0;
    logic [XLEN-1:0] o_reqAddr;
    logic            i_rspValid = 1'b0;
    logic [31:0]     i_rspData = '0;
    logic            o_instrValid;
    logic            i_decReady = 1'b0;
    logic [31:0]     o_instr;
    logic [XLEN-1:0] o_pc;
    logic            i_redirect = 1'b0;
    logic [XLEN-1:0] i_redirectPc = '0;

    always #5 clk = ~clk;

    fetch_queue #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .o_reqValid   (o_reqValid),
        .i_reqReady   (i_reqReady),
        .o_reqAddr    (o_reqAddr),
        .i_rspValid   (i_rspValid),
        .i_rspData    (i_rspData),
        .o_instrValid (o_instrValid),
        .i_decReady   (i_decReady),
        .o_instr      (o_instr),
        .o_pc         (o_pc),
        .i_redirect   (i_redirect),
        .i_redirectPc (i_redirectPc)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] pend_addr[$];
    int          pend_due[$];
    logic [31:0] pop_pc[$];
    logic [31:0] pop_ins[$];
    int          pop_cyc[$];
    int          cyc;
    int          lat;
    int          n_req;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] img(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    // Drive this cycle's memory response, then let combinational outputs settle.
    task automatic prep();
        i_rspValid = 1'b0;
        i_rspData  = '0;
        if (pend_addr.size() != 0 && pend_due[0] <= cyc) begin
            i_rspValid = 1'b1;
            i_rspData  = img(pend_addr[0]);
        end
        #1;
    endtask

    // Record handshakes of this cycle and move to the next falling edge.
    task automatic adv();
        logic        acc, pp;
        logic [31:0] a, ppc, pins;
        acc  = o_reqValid && i_reqReady;
        a    = o_reqAddr;
        pp   = o_instrValid && i_decReady && !i_redirect;
        ppc  = o_pc;
        pins = o_instr;
        @(posedge clk);
        if (i_rspValid) begin
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end
        if (acc) begin
            pend_addr.push_back(a);
            pend_due.push_back(cyc + lat);
            n_req++;
        end
        if (pp) begin
            pop_pc.push_back(ppc);
            pop_ins.push_back(pins);
            pop_cyc.push_back(cyc);
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            prep();
            adv();
        end
    endtask

    task automatic clear_logs();
        pop_pc.delete();
        pop_ins.delete();
        pop_cyc.delete();
    endtask

    task automatic do_reset(input int l, input logic rdy, input logic dec);
        rst        = 1'b0;
        i_rspValid = 1'b0;
        i_redirect = 1'b0;
        pend_addr.delete();
        pend_due.delete();
        clear_logs();
        repeat (2) @(negedge clk);
        lat        = l;
        i_reqReady = rdy;
        i_decReady = dec;
        rst        = 1'b1;
        cyc        = 0;
        n_req      = 0;
    endtask

    initial begin
        cyc = 0; lat = 1; n_req = 0;

        // Reset values while held in reset
        repeat (2) @(negedge clk);
        #1;
        check_val("rst_reqValid",   o_reqValid,   0);
        check_val("rst_instrValid", o_instrValid, 0);
        check_val("rst_instr",      o_instr,      0);
        check_val("rst_pc",         o_pc,         0);
        check_val("rst_reqAddr",    o_reqAddr,    0);

        // Zero-wait memory, decode always ready
        do_reset(1, 1'b1, 1'b1);
        prep();
        check_val("first_req_valid", o_reqValid, 1);
        check_val("first_req_addr",  o_reqAddr,  0);
        adv();
        tick(11);
        check_val("zw_npops", pop_pc.size() >= 8, 1);
        check_val("zw_first_cycle", pop_cyc[0], 2);
        for (int i = 0; i < 8; i++) begin
            check_val("zw_pc",    pop_pc[i],  32'(4 * i));
            check_val("zw_instr", pop_ins[i], img(32'(4 * i)));
        end
        check_val("zw_back_to_back", pop_cyc[7], 9);

        // Decode stalled: credit caps fetches at DEPTH
        do_reset(1, 1'b1, 1'b0);
        tick(10);
        prep();
        check_val("stall_reqValid", o_reqValid, 0);
        check_val("stall_nreq", n_req, 4);
        check_val("stall_count", dut.w_count, 4);
        check_val("stall_instrValid", o_instrValid, 1);
        check_val("stall_head_pc", o_pc, 0);
        adv();
        i_decReady = 1'b1;
        tick(12);
        for (int i = 0; i < 5; i++) check_val("release_pc", pop_pc[i], 32'(4 * i));
        check_val("release_consecutive", pop_cyc[3] - pop_cyc[0], 3);

        // Redirect with three requests in flight (latency 4)
        do_reset(4, 1'b1, 1'b1);
        tick(3);
        i_redirect = 1'b1; i_redirectPc = 32'h103;
        prep();
        check_val("redir_noreq", o_reqValid, 0);
        check_val("redir_outstanding", dut.r_outstanding, 3);
        adv();
        i_redirect = 1'b0;
        check_val("redir_drop", dut.r_drop, 3);
        prep();
        check_val("redir_addr",  o_reqAddr,  32'h100);
        check_val("redir_valid", o_reqValid, 1);
        adv();
        tick(15);
        check_val("redir_first_pc",    pop_pc[0],  32'h100);
        check_val("redir_first_instr", pop_ins[0], img(32'h100));
        check_val("redir_second_pc",   pop_pc[1],  32'h104);
        check_val("redir_drop_done",   dut.r_drop, 0);

        // Redirect coincident with a response and a pop
        do_reset(1, 1'b1, 1'b1);
        tick(4);
        i_redirect = 1'b1; i_redirectPc = 32'h200;
        prep();
        check_val("coinc_rsp_present", i_rspValid && o_instrValid, 1);
        check_val("coinc_outstanding", dut.r_outstanding, 1);
        adv();
        i_redirect = 1'b0;
        clear_logs();
        check_val("coinc_drop", dut.r_drop, 0);
        prep();
        check_val("coinc_instrValid", o_instrValid, 0);
        check_val("coinc_addr", o_reqAddr, 32'h200);
        adv();
        tick(6);
        check_val("coinc_first_pc",    pop_pc[0],  32'h200);
        check_val("coinc_first_instr", pop_ins[0], img(32'h200));

        // Address wrap at the top of the address space
        do_reset(1, 1'b1, 1'b1);
        i_redirect = 1'b1; i_redirectPc = 32'hFFFF_FFFC;
        prep();
        check_val("wrap_noreq", o_reqValid, 0);
        adv();
        i_redirect = 1'b0;
        prep();
        check_val("wrap_addr0", o_reqAddr, 32'hFFFF_FFFC);
        adv();
        prep();
        check_val("wrap_addr1", o_reqAddr, 32'h0);
        adv();
        tick(5);
        check_val("wrap_pc0", pop_pc[0], 32'hFFFF_FFFC);
        check_val("wrap_pc1", pop_pc[1], 32'h0);
        check_val("wrap_instr1", pop_ins[1], img(32'h0));

        // Memory not ready: address held, nothing accepted
        do_reset(1, 1'b0, 1'b1);
        tick(3);
        prep();
        check_val("hold_addr",  o_reqAddr,  0);
        check_val("hold_valid", o_reqValid, 1);
        check_val("hold_nreq",  n_req,      0);
        adv();

        // Reset mid-stream with two outstanding and a non-empty queue
        do_reset(2, 1'b1, 1'b0);
        tick(4);
        prep();
        check_val("mid_instrValid_pre", o_instrValid, 1);
        check_val("mid_outstanding_pre", dut.r_outstanding, 2);
        rst = 1'b0;
        i_rspValid = 1'b0;
        pend_addr.delete();
        pend_due.delete();
        #1;
        check_val("mid_reqValid",   o_reqValid,   0);
        check_val("mid_instrValid", o_instrValid, 0);
        check_val("mid_instr",      o_instr,      0);
        check_val("mid_pc",         o_pc,         0);
        check_val("mid_reqAddr",    o_reqAddr,    0);
        check_val("mid_outstanding", dut.r_outstanding, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("post_reqAddr",  o_reqAddr,   0);
        check_val("post_reqValid", o_reqValid,  1);
        check_val("post_count",    dut.w_count, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
